larson_scan_ctrl: RTL and testbench

LARSON_SCAN_CTRL -- requirements
Module: larson_scan_ctrl

---
 rtl/scanner_pkg.sv | 20 ++
 rtl/scan_prescaler.sv | 48 ++++
 rtl/larson_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_larson_scan_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/scanner_pkg.sv
// Shared types and width limits for the Larson scanner controller.
package scanner_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SCAN_UP   = 2'd1,
        SCAN_DOWN = 2'd2
    } scan_state_e;

    localparam int MAX_LEDS        = 16;
    localparam int MAX_POS_W       = 4;
    localparam int SPEED_W         = 2;
    localparam int MAX_SPEED_SHIFT = (1 << SPEED_W) - 1;

    // Counter width needed to hold the longest step period PRESCALE * 2^3.
    function automatic int presc_width(input int prescale);
        return $clog2(prescale * (1 << MAX_SPEED_SHIFT) + 1);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Step-period prescaler: counts 0..P-1 and pulses wrap_o on the last count.
// The period is sampled only while the count is 0, so a new period value
// never shortens or stretches a period already in progress.
module scan_prescaler
    import scanner_pkg::*;
#(
    parameter int CW = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [CW-1:0] period_i,
    output logic          wrap_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] per_q, per_d;
    logic [CW-1:0] per_eff;

    // Next count, period latch and wrap detect.
    always_comb begin
        per_eff = (cnt_q == '0) ? period_i : per_q;
        wrap_o  = en_i && !clr_i && (cnt_q == (per_eff - CW'(1)));
        cnt_d   = cnt_q;
        per_d   = per_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                per_d = period_i;
            end
            cnt_d = wrap_o ? '0 : (cnt_q + CW'(1));
        end
    end

    // Counter and latched period registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            per_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
        end
    end

endmodule

// File: rtl/larson_scan_ctrl.sv
// Larson (back-and-forth) LED scanner: FSM, position tracking and LED decode.
// All outputs come straight from flops.
module larson_scan_ctrl
    import scanner_pkg::*;
#(
    parameter int N_LEDS   = 8,
    parameter int PRESCALE = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic [SPEED_W-1:0]        i_speed,
    output logic [$clog2(N_LEDS)-1:0] o_pos,
    output logic [N_LEDS-1:0]         o_led_n,
    output logic                      o_dir,
    output logic                      o_step,
    output logic                      o_bounce
);

    localparam int POS_W = $clog2(N_LEDS);
    localparam int CW    = presc_width(PRESCALE);

    localparam logic [POS_W-1:0] POS_TOP      = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] POS_BELOW_TOP = POS_W'(N_LEDS - 2);
    localparam logic [POS_W-1:0] POS_ONE      = POS_W'(1);

    scan_state_e       state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              dir_q, dir_d;
    logic [N_LEDS-1:0] led_n_q, led_n_d;
    logic              step_q, step_d;
    logic              bounce_q, bounce_d;

    logic              presc_run;
    logic              presc_wrap;
    logic [CW-1:0]     period;

    // Prescaler only runs while scanning and staying enabled; dropping i_en
    // clears it on the same edge so a coincident wrap is discarded.
    always_comb begin
        presc_run = i_en && (state_q != IDLE);
        period    = CW'(PRESCALE) << i_speed;
    end

    scan_prescaler #(
        .CW (CW)
    ) u_presc (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .en_i     (presc_run),
        .clr_i    (!presc_run),
        .period_i (period),
        .wrap_o   (presc_wrap)
    );

    // Next-state, position, direction, pulse and LED decode.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        bounce_d = 1'b0;
        if (!i_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = dir_q ? SCAN_DOWN : SCAN_UP;
                end
                SCAN_UP: begin
                    if (presc_wrap) begin
                        step_d = 1'b1;
                        if (pos_q == POS_TOP) begin
                            pos_d    = POS_BELOW_TOP;
                            state_d  = SCAN_DOWN;
                            dir_d    = 1'b1;
                            bounce_d = 1'b1;
                        end else begin
                            pos_d = pos_q + POS_ONE;
                        end
                    end
                end
                SCAN_DOWN: begin
                    if (presc_wrap) begin
                        step_d = 1'b1;
                        if (pos_q == '0) begin
                            pos_d    = POS_ONE;
                            state_d  = SCAN_UP;
                            dir_d    = 1'b0;
                            bounce_d = 1'b1;
                        end else begin
                            pos_d = pos_q - POS_ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        if (state_d == IDLE) begin
            led_n_d = '1;
        end else begin
            led_n_d = ~(N_LEDS'(1) << pos_d);
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            led_n_q  <= '1;
            step_q   <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            led_n_q  <= led_n_d;
            step_q   <= step_d;
            bounce_q <= bounce_d;
        end
    end

    assign o_pos    = pos_q;
    assign o_led_n  = led_n_q;
    assign o_dir    = dir_q;
    assign o_step   = step_q;
    assign o_bounce = bounce_q;

endmodule

// File: tb/tb_larson_scan_ctrl.sv
// Directed bench: 8-LED/PRESCALE=4 scanner plus a 2-LED/PRESCALE=1 instance.
module tb_larson_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [1:0] spd;
    logic [2:0] pos;
    logic [7:0] led_n;
    logic       dir, step, bounce;

    logic       b_rst, b_en;
    logic [1:0] b_spd;
    logic [0:0] b_pos;
    logic [1:0] b_led_n;
    logic       b_dir, b_step, b_bounce;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    larson_scan_ctrl #(.N_LEDS(8), .PRESCALE(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_speed(spd),
        .o_pos(pos), .o_led_n(led_n), .o_dir(dir), .o_step(step), .o_bounce(bounce)
    );

    larson_scan_ctrl #(.N_LEDS(2), .PRESCALE(1)) dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_en(b_en), .i_speed(b_spd),
        .o_pos(b_pos), .o_led_n(b_led_n), .o_dir(b_dir), .o_step(b_step), .o_bounce(b_bounce)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [2:0] e_pos, input logic [7:0] e_led,
                           input logic e_dir, input logic e_step, input logic e_bounce);
        check({tag, ".pos"},    32'(pos),    32'(e_pos));
        check({tag, ".led_n"},  32'(led_n),  32'(e_led));
        check({tag, ".dir"},    32'(dir),    32'(e_dir));
        check({tag, ".step"},   32'(step),   32'(e_step));
        check({tag, ".bounce"}, 32'(bounce), 32'(e_bounce));
    endtask

    task automatic check_b(input string tag, input logic e_pos, input logic [1:0] e_led,
                           input logic e_dir, input logic e_step, input logic e_bounce);
        check({tag, ".pos"},    32'(b_pos),    32'(e_pos));
        check({tag, ".led_n"},  32'(b_led_n),  32'(e_led));
        check({tag, ".dir"},    32'(b_dir),    32'(e_dir));
        check({tag, ".step"},   32'(b_step),   32'(e_step));
        check({tag, ".bounce"}, 32'(b_bounce), 32'(e_bounce));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; spd = 2'd0;
        b_rst = 1'b1; b_en = 1'b0; b_spd = 2'd0;
        tick(2);
        rst = 1'b0; b_rst = 1'b0;
        check_a("reset", 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0);
        check_b("b_reset", 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);

        // Enable: one edge to enter SCAN_UP, then 4 cycles per step.
        en = 1'b1;
        tick(1);
        check_a("enter_up", 3'd0, 8'hFE, 1'b0, 1'b0, 1'b0);
        tick(3);
        check_a("pre_step1", 3'd0, 8'hFE, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_a("step1", 3'd1, 8'hFD, 1'b0, 1'b1, 1'b0);
        tick(24);
        check_a("pos7", 3'd7, 8'h7F, 1'b0, 1'b1, 1'b0);
        tick(4);
        check_a("bounce_top", 3'd6, 8'hBF, 1'b1, 1'b1, 1'b1);
        tick(1);
        check_a("after_bounce", 3'd6, 8'hBF, 1'b1, 1'b0, 1'b0);
        tick(3);
        check_a("pos5_down", 3'd5, 8'hDF, 1'b1, 1'b1, 1'b0);

        // Freeze at pos 5 going down.
        en = 1'b0;
        tick(1);
        check_a("idle_enter", 3'd5, 8'hFF, 1'b1, 1'b0, 1'b0);
        tick(9);
        check_a("idle_hold", 3'd5, 8'hFF, 1'b1, 1'b0, 1'b0);
        en = 1'b1;
        tick(1);
        check_a("resume", 3'd5, 8'hDF, 1'b1, 1'b0, 1'b0);
        tick(3);
        check("resume_wait.pos", 32'(pos), 32'd5);
        tick(1);
        check_a("resume_step", 3'd4, 8'hEF, 1'b1, 1'b1, 1'b0);

        // Speed 2: 16-cycle period; change to 0 mid-period.
        spd = 2'd2;
        tick(15);
        check_a("slow_wait", 3'd4, 8'hEF, 1'b1, 1'b0, 1'b0);
        tick(1);
        check_a("slow_step", 3'd3, 8'hF7, 1'b1, 1'b1, 1'b0);
        tick(8);
        spd = 2'd0;
        tick(7);
        check_a("slow_finish_wait", 3'd3, 8'hF7, 1'b1, 1'b0, 1'b0);
        tick(1);
        check_a("slow_finish", 3'd2, 8'hFB, 1'b1, 1'b1, 1'b0);
        tick(4);
        check_a("fast_again", 3'd1, 8'hFD, 1'b1, 1'b1, 1'b0);

        // i_en falls exactly on the step edge.
        tick(3);
        check("pre_drop.step", 32'(step), 32'd0);
        en = 1'b0;
        tick(1);
        check_a("drop_on_step", 3'd1, 8'hFF, 1'b1, 1'b0, 1'b0);
        tick(2);
        check("drop_hold.pos", 32'(pos), 32'd1);

        // Bottom bounce, then reset mid-period at pos 6.
        en = 1'b1;
        tick(1);
        tick(4);
        check_a("pos0", 3'd0, 8'hFE, 1'b1, 1'b1, 1'b0);
        tick(4);
        check_a("bounce_bottom", 3'd1, 8'hFD, 1'b0, 1'b1, 1'b1);
        tick(20);
        check_a("pos6_up", 3'd6, 8'hBF, 1'b0, 1'b1, 1'b0);
        tick(3);
        rst = 1'b1;
        tick(1);
        check_a("mid_reset", 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_a("reset_hold_en", 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(1);
        check_a("post_reset", 3'd0, 8'hFE, 1'b0, 1'b0, 1'b0);

        // Two LEDs, PRESCALE=1: step every cycle, bounce on every step after the first.
        b_en = 1'b1;
        tick(1);
        check_b("b_enter", 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_b("b_s1", 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
        tick(1);
        check_b("b_s2", 1'b0, 2'b10, 1'b1, 1'b1, 1'b1);
        tick(1);
        check_b("b_s3", 1'b1, 2'b01, 1'b0, 1'b1, 1'b1);
        tick(1);
        check_b("b_s4", 1'b0, 2'b10, 1'b1, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
